// File: rtl/instr_queue.sv
// ============================================================================
// Module   : instr_queue (with package tomasula_types)
// Purpose  : In-order decoded-instruction FIFO feeding ROB / RS dispatch.
//            Optional zero-latency bypass when built with IQ_BYPASS_EN.
// Revision : 1.0
// ============================================================================
`default_nettype none

package tomasula_types;
  typedef enum logic [2:0] {
    OP_ALU    = 3'd0,
    OP_LOAD   = 3'd1,
    OP_STORE  = 3'd2,
    OP_BRANCH = 3'd3,
    OP_JUMP   = 3'd4
  } op_t;
endpackage

module instr_queue #(
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       enq_valid,
  output logic                       enq_ready,
  input  tomasula_types::op_t        enq_op,
  input  logic [4:0]                 enq_rd,
  input  logic [4:0]                 enq_rs1,
  input  logic [4:0]                 enq_rs2,
  input  logic [31:0]                enq_imm,
  input  logic [31:0]                enq_pc,
  input  logic                       rob_full,
  input  logic                       rs_ready,
  input  logic [2:0]                 rob_curr_ptr,
  input  logic                       branch_mispredict,
  output logic                       rob_load,
  output tomasula_types::op_t        instr_type,
  output logic [4:0]                 rd,
  output logic [4:0]                 st_src,
  output logic [4:0]                 disp_rs1,
  output logic [4:0]                 disp_rs2,
  output logic [31:0]                disp_imm,
  output logic [31:0]                disp_pc,
  output logic [2:0]                 disp_rob_tag,
  output logic [$clog2(DEPTH):0]     iq_count,
  output logic                       iq_empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  typedef struct packed {
    tomasula_types::op_t op;
    logic [4:0]          rd;
    logic [4:0]          rs1;
    logic [4:0]          rs2;
    logic [31:0]         imm;
    logic [31:0]         pc;
  } entry_t;

  entry_t        mem_q [DEPTH];
  logic [AW-1:0] head_q, head_d;
  logic [AW-1:0] tail_q, tail_d;
  logic [AW:0]   count_q, count_d;

  logic   is_empty, is_full;
  logic   disp_fire, enq_fire, bypass;
  entry_t enq_e, out_e;

  assign is_empty  = (count_q == '0);
  assign is_full   = (count_q == FULL_CNT);
  assign enq_ready = !is_full;
  assign disp_fire = !is_empty && !rob_full && rs_ready && !branch_mispredict;

`ifdef IQ_BYPASS_EN
  assign bypass = is_empty && enq_valid && !rob_full && rs_ready && !branch_mispredict;
`else
  assign bypass = 1'b0;
`endif

  // A bypassed instruction is consumed directly and never occupies a slot.
  assign enq_fire = enq_valid && enq_ready && !branch_mispredict && !bypass;

  assign enq_e = '{op: enq_op, rd: enq_rd, rs1: enq_rs1, rs2: enq_rs2,
                   imm: enq_imm, pc: enq_pc};

  always_comb begin
    out_e = mem_q[head_q];
    if (bypass) out_e = enq_e;
  end

  assign rob_load     = disp_fire || bypass;
  assign instr_type   = out_e.op;
  assign rd           = out_e.rd;
  assign st_src       = out_e.rs2;
  assign disp_rs1     = out_e.rs1;
  assign disp_rs2     = out_e.rs2;
  assign disp_imm     = out_e.imm;
  assign disp_pc      = out_e.pc;
  assign disp_rob_tag = rob_load ? rob_curr_ptr : 3'd0;
  assign iq_count     = count_q;
  assign iq_empty     = is_empty;

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (branch_mispredict) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (enq_fire)  tail_d = tail_q + 1'b1;
      if (disp_fire) head_d = head_q + 1'b1;
      case ({enq_fire, disp_fire})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      if (enq_fire) mem_q[tail_q] <= enq_e;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_instr_queue.sv
// ============================================================================
// Module   : tb_instr_queue
// Purpose  : Directed self-checking bench for instr_queue against a queue model.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_instr_queue;
  import tomasula_types::*;

  localparam int DEPTH = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        enq_valid = 1'b0;
  logic        enq_ready;
  op_t         enq_op = OP_ALU;
  logic [4:0]  enq_rd = '0, enq_rs1 = '0, enq_rs2 = '0;
  logic [31:0] enq_imm = '0, enq_pc = '0;
  logic        rob_full = 1'b0, rs_ready = 1'b0, branch_mispredict = 1'b0;
  logic [2:0]  rob_curr_ptr = '0;
  logic        rob_load;
  op_t         instr_type;
  logic [4:0]  rd, st_src, disp_rs1, disp_rs2;
  logic [31:0] disp_imm, disp_pc;
  logic [2:0]  disp_rob_tag;
  logic [3:0]  iq_count;
  logic        iq_empty;

  int vectors = 0;
  int miscompares = 0;

  instr_queue #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .enq_valid(enq_valid), .enq_ready(enq_ready), .enq_op(enq_op),
    .enq_rd(enq_rd), .enq_rs1(enq_rs1), .enq_rs2(enq_rs2),
    .enq_imm(enq_imm), .enq_pc(enq_pc),
    .rob_full(rob_full), .rs_ready(rs_ready), .rob_curr_ptr(rob_curr_ptr),
    .branch_mispredict(branch_mispredict),
    .rob_load(rob_load), .instr_type(instr_type), .rd(rd), .st_src(st_src),
    .disp_rs1(disp_rs1), .disp_rs2(disp_rs2), .disp_imm(disp_imm),
    .disp_pc(disp_pc), .disp_rob_tag(disp_rob_tag),
    .iq_count(iq_count), .iq_empty(iq_empty)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    logic [2:0]  op;
    logic [4:0]  rd, rs1, rs2;
    logic [31:0] imm, pc;
  } ent_t;

  ent_t q[$];
  bit   fresh = 1'b1;

  function automatic ent_t cur_in();
    ent_t e;
    e.op = enq_op; e.rd = enq_rd; e.rs1 = enq_rs1; e.rs2 = enq_rs2;
    e.imm = enq_imm; e.pc = enq_pc;
    return e;
  endfunction

  function automatic bit m_bypass();
`ifdef IQ_BYPASS_EN
    return (q.size() == 0) && enq_valid && !rob_full && rs_ready && !branch_mispredict;
`else
    return 1'b0;
`endif
  endfunction

  function automatic bit m_load();
    return ((q.size() != 0) && !rob_full && rs_ready && !branch_mispredict) || m_bypass();
  endfunction

  always @(negedge rst) begin
    q.delete();
    fresh = 1'b1;
  end

  always @(posedge clk) begin
    if (!rst) begin
      q.delete();
      fresh = 1'b1;
    end else if (branch_mispredict) begin
      q.delete();
    end else begin
      bit was_full, byp, ld;
      was_full = (q.size() == DEPTH);
      byp = m_bypass();
      ld  = m_load();
      if (ld && !byp) void'(q.pop_front());
      if (enq_valid && !was_full && !byp) begin
        q.push_back(cur_in());
        fresh = 1'b0;
      end
    end
  end

  // Per-cycle comparison of every meaningful output against the model.
  always @(negedge clk) begin
    ent_t e;
    bit   show;
    bit   ld;
    ld   = m_load();
    show = 1'b1;
    if (m_bypass())        e = cur_in();
    else if (q.size() > 0) e = q[0];
    else if (fresh)        e = '{op: 3'd0, rd: 5'd0, rs1: 5'd0, rs2: 5'd0, imm: 32'd0, pc: 32'd0};
    else                   show = 1'b0;
    chk("m_enq_ready", 32'(enq_ready), 32'(q.size() != DEPTH));
    chk("m_iq_count",  32'(iq_count),  32'(q.size()));
    chk("m_iq_empty",  32'(iq_empty),  32'(q.size() == 0));
    chk("m_rob_load",  32'(rob_load),  32'(ld));
    if (ld) chk("m_tag", 32'(disp_rob_tag), 32'(rob_curr_ptr));
    if (show) begin
      chk("m_op",  32'(instr_type), 32'(e.op));
      chk("m_rd",  32'(rd),         32'(e.rd));
      chk("m_st",  32'(st_src),     32'(e.rs2));
      chk("m_rs1", 32'(disp_rs1),   32'(e.rs1));
      chk("m_rs2", 32'(disp_rs2),   32'(e.rs2));
      chk("m_imm", disp_imm,        e.imm);
      chk("m_pc",  disp_pc,         e.pc);
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_enq(input bit v, input logic [31:0] pc);
    enq_valid = v;
    enq_pc    = pc;
    enq_op    = op_t'(3'(pc[4:2] % 5));
    enq_rd    = pc[6:2];
    enq_rs1   = pc[7:3];
    enq_rs2   = ~pc[6:2];
    enq_imm   = pc ^ 32'hA5A5_0000;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    set_enq(1'b0, 32'd0);
    // Reset then idle
    @(negedge clk);
    chk("rst_enq_ready", 32'(enq_ready), 32'd1);
    chk("rst_empty",     32'(iq_empty),  32'd1);
    chk("rst_load",      32'(rob_load),  32'd0);
    chk("rst_pc",        disp_pc,        32'd0);
    chk("rst_count",     32'(iq_count),  32'd0);
    step(); step();
    rst = 1'b1;

    // Fill with ROB full
    rob_full = 1'b1; rs_ready = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      set_enq(1'b1, 32'h100 + 32'(4*i));
      step();
    end
    set_enq(1'b1, 32'h999);
    @(negedge clk);
    chk("fill_count", 32'(iq_count),  32'd8);
    chk("fill_ready", 32'(enq_ready), 32'd0);
    step();
    set_enq(1'b0, 32'd0);

    // Drain in order with ROB tags 3..2
    rob_full = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      rob_curr_ptr = 3'((3 + i) % 8);
      @(negedge clk);
      chk("drain_count", 32'(iq_count),     32'(8 - i));
      chk("drain_load",  32'(rob_load),     32'd1);
      chk("drain_pc",    disp_pc,           32'h100 + 32'(4*i));
      chk("drain_tag",   32'(disp_rob_tag), 32'((3 + i) % 8));
      step();
    end
    @(negedge clk);
    chk("drain_empty", 32'(iq_empty), 32'd1);
    chk("drain_idle",  32'(rob_load), 32'd0);
    step();

    // Simultaneous enqueue/dispatch across pointer wrap
    rob_full = 1'b1;
    set_enq(1'b1, 32'h300); step();
    set_enq(1'b1, 32'h304); step();
    rob_full = 1'b0;
    for (int k = 0; k < 20; k++) begin
      set_enq(1'b1, 32'h308 + 32'(4*k));
      @(negedge clk);
      chk("wrap_count", 32'(iq_count), 32'd2);
      chk("wrap_load",  32'(rob_load), 32'd1);
      chk("wrap_pc",    disp_pc,       32'h300 + 32'(4*k));
      step();
    end
    set_enq(1'b0, 32'd0);
    rob_full = 1'b1;
    @(negedge clk);
    chk("wrap_final", 32'(iq_count), 32'd2);
    step();

    // Stall to 5 entries, then flush with a concurrent enqueue
    rob_full = 1'b0; rs_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      set_enq(1'b1, 32'h500 + 32'(4*i));
      step();
    end
    set_enq(1'b0, 32'd0);
    @(negedge clk);
    chk("stall_count", 32'(iq_count), 32'd5);
    chk("stall_load",  32'(rob_load), 32'd0);
    step();
    branch_mispredict = 1'b1; rs_ready = 1'b1;
    set_enq(1'b1, 32'hBAD0);
    @(negedge clk);
    chk("flush_load", 32'(rob_load), 32'd0);
    step();
    branch_mispredict = 1'b0;
    set_enq(1'b0, 32'd0);
    @(negedge clk);
    chk("flush_count", 32'(iq_count), 32'd0);
    chk("flush_empty", 32'(iq_empty), 32'd1);
    chk("flush_noload", 32'(rob_load), 32'd0);
    step();

    // Bypass behaviour on an empty queue
    rob_full = 1'b0; rs_ready = 1'b1;
    set_enq(1'b1, 32'h200);
    @(negedge clk);
`ifdef IQ_BYPASS_EN
    chk("byp_load",  32'(rob_load), 32'd1);
    chk("byp_pc",    disp_pc,       32'h200);
    chk("byp_count", 32'(iq_count), 32'd0);
    step();
    set_enq(1'b0, 32'd0);
    @(negedge clk);
    chk("byp_after_count", 32'(iq_count), 32'd0);
    chk("byp_after_load",  32'(rob_load), 32'd0);
`else
    chk("nobyp_load0", 32'(rob_load), 32'd0);
    chk("nobyp_count", 32'(iq_count), 32'd0);
    step();
    set_enq(1'b0, 32'd0);
    @(negedge clk);
    chk("nobyp_load1", 32'(rob_load), 32'd1);
    chk("nobyp_pc",    disp_pc,       32'h200);
    chk("nobyp_cnt1",  32'(iq_count), 32'd1);
    step();
    @(negedge clk);
    chk("nobyp_cnt0",  32'(iq_count), 32'd0);
`endif
    step();

    // Mid-stream asynchronous reset, then first enqueue lands at entry 0
    rob_full = 1'b1;
    for (int i = 0; i < 3; i++) begin
      set_enq(1'b1, 32'h600 + 32'(4*i));
      step();
    end
    set_enq(1'b0, 32'd0);
    #2 rst = 1'b0;
    #1;
    chk("mrst_count", 32'(iq_count), 32'd0);
    chk("mrst_empty", 32'(iq_empty), 32'd1);
    chk("mrst_pc",    disp_pc,       32'd0);
    step();
    rst = 1'b1;
    set_enq(1'b1, 32'h400);
    step();
    set_enq(1'b0, 32'd0);
    @(negedge clk);
    chk("mrst_count1", 32'(iq_count), 32'd1);
    chk("mrst_pc1",    disp_pc,       32'h400);
    step();
    rob_full = 1'b0;
    step(); step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
